// File: rtl/multi_cycle_core_if.sv
// Memory-side bus of multi_cycle_core.
// master : the core (drives requests, address, store data)
// slave  : the instruction/data memory (drives acks and read data)
//   imem_req/imem_addr   -> fetch request, held until imem_ack
//   imem_ack/imem_rdata  <- fetch complete, data valid with ack
//   dmem_req/we/addr/wdata -> data access, held until dmem_ack
//   dmem_ack/dmem_rdata  <- access complete, load data valid with ack
interface multi_cycle_core_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/multi_cycle_core.sv
// Multi-cycle RV32I core (integer ops, LUI, AUIPC, JAL, JALR, branches, LW, SW).
// One instruction at a time through FETCH -> DECODE -> EXECUTE -> [MEM] -> WB.
// Any memory wait that reaches TIMEOUT, a misaligned or non-word LW/SW, or an
// unknown opcode parks the core in FAULT until reset.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   bus          memory bus (master side)
//   pc_address   current PC
//   alu_output   latched ALU result (also the data address in MEM)
//   reg1_output  architectural x1
//   retire       one-cycle pulse in the WB cycle
//   fault        sticky fault flag
module multi_cycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  multi_cycle_core_if.master         bus,
  output logic [31:0]                pc_address,
  output logic [31:0]                alu_output,
  output logic [31:0]                reg1_output,
  output logic                       retire,
  output logic                       fault
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_FAULT   = 3'd7
  } state_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  // Wait counter wide enough to hold TIMEOUT; saturates so TIMEOUT=0 never wraps.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  state_t      state;
  logic [31:0] pc, ir, op_a, op_b, alu_q, ld_q;
  logic [CW-1:0] wcnt;
  logic        take_q;
  logic        imem_req_q, dmem_req_q, dmem_we_q;
  logic        retire_q, fault_q;

  logic [31:0] rf [32];

  // ---------------- decode (combinational from IR) ----------------
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] pc_plus4;

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign f3       = ir[14:12];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign imm_i    = {{20{ir[31]}}, ir[31:20]};
  assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u    = {ir[31:12], 12'd0};
  assign imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign pc_plus4 = pc + 32'd4;

  logic is_jump, has_rd;
  assign is_jump = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign has_rd  = (opcode == OP_LUI) || (opcode == OP_AUIPC) || is_jump ||
                   (opcode == OP_LOAD) || (opcode == OP_IMM) || (opcode == OP_REG);

  // ---------------- execute units ----------------
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] fn, input logic alt);
    logic [31:0] r;
    case (fn)
      3'b000:  r = alt ? (a - b) : (a + b);
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'd0, $signed(a) < $signed(b)};
      3'b011:  r = {31'd0, a < b};
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic br_f(input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] fn);
    logic t;
    case (fn)
      3'b000:  t = (a == b);
      3'b001:  t = (a != b);
      3'b100:  t = $signed(a) <  $signed(b);
      3'b101:  t = $signed(a) >= $signed(b);
      3'b110:  t = a <  b;
      3'b111:  t = a >= b;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  logic [31:0] ex_res;
  logic        ex_take, ex_ok, ex_mem;

  always_comb begin
    ex_res  = '0;
    ex_take = 1'b0;
    ex_ok   = 1'b1;
    ex_mem  = 1'b0;
    case (opcode)
      OP_LUI:   ex_res = imm_u;
      OP_AUIPC: ex_res = pc + imm_u;
      OP_JAL: begin
        ex_res  = pc + imm_j;
        ex_take = 1'b1;
      end
      OP_JALR: begin
        ex_res  = (op_a + imm_i) & ~32'd1;
        ex_take = 1'b1;
      end
      OP_BR: begin
        ex_res  = pc + imm_b;
        ex_take = br_f(op_a, op_b, f3);
      end
      OP_LOAD, OP_STORE: begin
        ex_res = op_a + ((opcode == OP_LOAD) ? imm_i : imm_s);
        ex_mem = 1'b1;
        // Only word accesses, only word-aligned.
        ex_ok  = (f3 == 3'b010) && (ex_res[1:0] == 2'b00);
      end
      // Bit 30 means SRAI only for the shift-right encoding; for other
      // immediates it is just an immediate bit.
      OP_IMM:   ex_res = alu_f(op_a, imm_i, f3, (f3 == 3'b101) && ir[30]);
      OP_REG:   ex_res = alu_f(op_a, op_b, f3, ir[30]);
      default:  ex_ok  = 1'b0;
    endcase
  end

  // ---------------- register file ----------------
  logic [31:0] rs1_data, rs2_data, wb_data;
  assign rs1_data = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_data = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign wb_data  = is_jump ? pc_plus4 : (opcode == OP_LOAD) ? ld_q : alu_q;

  // Contents are deliberately not reset; state is never WB during reset.
  always_ff @(posedge clk) begin
    if (state == S_WB && has_rd && rd != 5'd0)
      rf[rd] <= wb_data;
  end

  // ---------------- control FSM ----------------
  logic [CW-1:0] wcnt_inc;
  logic          timeout_hit;
  assign wcnt_inc    = (&wcnt) ? wcnt : wcnt + 1'b1;
  // Only reached on a request cycle without ack, so an ack always wins.
  assign timeout_hit = (TIMEOUT != 0) && (wcnt_inc == TO_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      alu_q      <= '0;
      ld_q       <= '0;
      wcnt       <= '0;
      take_q     <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      retire_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state)
        S_FETCH: begin
          // After reset the request is raised on the first edge; after WB it
          // is already high on entry.
          if (!imem_req_q) begin
            imem_req_q <= 1'b1;
            wcnt       <= '0;
          end else if (bus.imem_ack) begin
            ir         <= bus.imem_rdata;
            imem_req_q <= 1'b0;
            state      <= S_DECODE;
          end else if (timeout_hit) begin
            imem_req_q <= 1'b0;
            fault_q    <= 1'b1;
            state      <= S_FAULT;
          end else begin
            wcnt <= wcnt_inc;
          end
        end
        S_DECODE: begin
          op_a  <= rs1_data;
          op_b  <= rs2_data;
          state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          alu_q  <= ex_res;
          take_q <= ex_take;
          if (!ex_ok) begin
            fault_q <= 1'b1;
            state   <= S_FAULT;
          end else if (ex_mem) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= (opcode == OP_STORE);
            wcnt       <= '0;
            state      <= S_MEM;
          end else begin
            retire_q <= 1'b1;
            state    <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            if (!dmem_we_q) ld_q <= bus.dmem_rdata;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            retire_q   <= 1'b1;
            state      <= S_WB;
          end else if (timeout_hit) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            fault_q    <= 1'b1;
            state      <= S_FAULT;
          end else begin
            wcnt <= wcnt_inc;
          end
        end
        S_WB: begin
          pc         <= take_q ? alu_q : pc_plus4;
          imem_req_q <= 1'b1;
          wcnt       <= '0;
          state      <= S_FETCH;
        end
        S_FAULT: fault_q <= 1'b1;
        default: begin
          imem_req_q <= 1'b0;
          dmem_req_q <= 1'b0;
          dmem_we_q  <= 1'b0;
          fault_q    <= 1'b1;
          state      <= S_FAULT;
        end
      endcase
    end
  end

  // Address/data come straight from registers that only change outside the
  // request window, so they are stable while a request is high.
  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = alu_q;
  assign bus.dmem_wdata = op_b;

  assign pc_address  = pc;
  assign alu_output  = alu_q;
  assign reg1_output = rf[1];
  assign retire      = retire_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_multi_cycle_core.sv
module tb_multi_cycle_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] pc_address, alu_output, reg1_output;
  logic retire, fault;

  multi_cycle_core_if mif ();

  multi_cycle_core #(.RESET_PC(32'h0000_0000), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (mif.master),
    .pc_address (pc_address),
    .alu_output (alu_output),
    .reg1_output(reg1_output),
    .retire     (retire),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  typedef struct {
    int          lat;
    logic [31:0] pc;
    logic [31:0] x1;
    int          iwait;
    int          dwait;
    bit          mem;
    bit          we;
    logic [31:0] daddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];

  logic [31:0] imem [32];
  logic [31:0] dmem [32];

  bit ack_storm = 1'b0;
  bit imem_en   = 1'b1;
  bit in_instr  = 1'b0;
  bit chk_pend  = 1'b0;
  bit saw_dreq  = 1'b0;
  int cyc = 0, start = 0, icnt = 0, dcnt = 0;

  task automatic push(input int lat, input logic [31:0] pc, input logic [31:0] x1,
                      input int iwait, input int dwait, input bit mem, input bit we,
                      input logic [31:0] daddr, input logic [31:0] wdata);
    exp_t e;
    e.lat = lat; e.pc = pc; e.x1 = x1; e.iwait = iwait; e.dwait = dwait;
    e.mem = mem; e.we = we; e.daddr = daddr; e.wdata = wdata;
    sb.push_back(e);
  endtask

  initial begin
    mif.imem_ack = 1'b0; mif.imem_rdata = '0;
    mif.dmem_ack = 1'b0; mif.dmem_rdata = '0;
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      in_instr = 1'b0;
      chk_pend = 1'b0;
      icnt = 0;
      dcnt = 0;
      if (ack_storm) begin
        mif.imem_ack = ~mif.imem_ack;
        mif.dmem_ack = ~mif.dmem_ack;
      end else begin
        mif.imem_ack = 1'b0;
        mif.dmem_ack = 1'b0;
      end
    end else begin
      if (chk_pend) begin
        chk("pc_after", pc_address, sb[0].pc);
        chk("x1_after", reg1_output, sb[0].x1);
        void'(sb.pop_front());
        chk_pend = 1'b0;
        saw_dreq = 1'b0;
      end
      if (retire) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire", retire, 1'b0);
        end else begin
          chk("latency", cyc - start + 1, sb[0].lat);
          chk_pend = 1'b1;
        end
        in_instr = 1'b0;
      end else if (mif.imem_req && !in_instr) begin
        in_instr = 1'b1;
        start = cyc;
      end

      if (mif.imem_req && imem_en) begin
        if (icnt >= ((sb.size() != 0) ? sb[0].iwait : 0)) begin
          mif.imem_ack   = 1'b1;
          mif.imem_rdata = imem[mif.imem_addr[6:2]];
        end else begin
          mif.imem_ack = 1'b0;
          icnt++;
        end
      end else begin
        mif.imem_ack = 1'b0;
        icnt = 0;
      end

      if (mif.dmem_req) begin
        saw_dreq = 1'b1;
        if (sb.size() == 0 || !sb[0].mem) begin
          chk("unexpected_dreq", mif.dmem_req, 1'b0);
          mif.dmem_ack = 1'b0;
        end else begin
          chk("dmem_we", mif.dmem_we, sb[0].we);
          chk("dmem_addr", mif.dmem_addr, sb[0].daddr);
          if (sb[0].we) chk("dmem_wdata", mif.dmem_wdata, sb[0].wdata);
          if (dcnt >= sb[0].dwait) begin
            mif.dmem_ack = 1'b1;
            if (mif.dmem_we) dmem[mif.dmem_addr[6:2]] = mif.dmem_wdata;
            else mif.dmem_rdata = dmem[mif.dmem_addr[6:2]];
          end else begin
            mif.dmem_ack = 1'b0;
            dcnt++;
          end
        end
      end else begin
        mif.dmem_ack = 1'b0;
        dcnt = 0;
      end
    end
  end

  initial begin
    int nreq;
    for (int i = 0; i < 32; i++) begin
      imem[i] = 32'h0000_0000;
      dmem[i] = 32'h0000_0000;
    end
    imem[0]  = 32'h00500093;
    imem[1]  = 32'h00000463;
    imem[3]  = 32'h010000EF;
    imem[7]  = 32'h01000113;
    imem[8]  = 32'h00500093;
    imem[9]  = 32'h00102223;
    imem[10] = 32'h00012083;
    imem[11] = 32'h00402083;
    imem[12] = 32'h002080B3;
    imem[13] = 32'h00109463;
    imem[14] = 32'hABCDE0B7;
    imem[15] = 32'h00100013;
    imem[16] = 32'h00012083;
    imem[17] = 32'h050000E7;
    imem[20] = 32'h00112083;
    dmem[4]  = 32'hDEADBEEF;

    push(4,  32'd4,  32'd5,        0, 0, 0, 0, 32'd0, 32'd0);
    push(4,  32'd12, 32'd5,        0, 0, 0, 0, 32'd0, 32'd0);
    push(4,  32'd28, 32'd16,       0, 0, 0, 0, 32'd0, 32'd0);
    push(4,  32'd32, 32'd16,       0, 0, 0, 0, 32'd0, 32'd0);
    push(4,  32'd36, 32'd5,        0, 0, 0, 0, 32'd0, 32'd0);
    push(5,  32'd40, 32'd5,        0, 0, 1, 1, 32'd4, 32'd5);
    push(8,  32'd44, 32'hDEADBEEF, 0, 3, 1, 0, 32'h10, 32'd0);
    push(5,  32'd48, 32'd5,        0, 0, 1, 0, 32'd4, 32'd0);
    push(4,  32'd52, 32'd21,       0, 0, 0, 0, 32'd0, 32'd0);
    push(4,  32'd56, 32'd21,       0, 0, 0, 0, 32'd0, 32'd0);
    push(4,  32'd60, 32'hABCDE000, 0, 0, 0, 0, 32'd0, 32'd0);
    push(6,  32'd64, 32'hABCDE000, 2, 0, 0, 0, 32'd0, 32'd0);
    push(12, 32'd68, 32'hDEADBEEF, 0, 7, 1, 0, 32'h10, 32'd0);
    push(4,  32'd80, 32'd72,       0, 0, 0, 0, 32'd0, 32'd0);

    ack_storm = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_pc", pc_address, 32'd0);
    chk("rst_imem_req", mif.imem_req, 1'b0);
    chk("rst_dmem_req", mif.dmem_req, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_retire", retire, 1'b0);
    #2;
    ack_storm = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_imem_req", mif.imem_req, 1'b1);
    chk("rel_imem_addr", mif.imem_addr, 32'd0);

    for (int i = 0; i < 400 && (sb.size() != 0 || chk_pend); i++) @(negedge clk);
    chk("program_done", sb.size(), 0);

    for (int i = 0; i < 20 && !fault; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("mis_fault", fault, 1'b1);
    chk("mis_no_dreq", saw_dreq, 1'b0);
    chk("mis_imem_req", mif.imem_req, 1'b0);
    chk("mis_pc", pc_address, 32'd80);
    chk("mis_x1", reg1_output, 32'd72);

    #2;
    rst = 1'b0;
    imem_en = 1'b0;
    #1;
    chk("rst2_pc", pc_address, 32'd0);
    chk("rst2_fault", fault, 1'b0);
    #5;
    rst = 1'b1;
    nreq = 0;
    for (int i = 0; i < 40 && !fault; i++) begin
      @(negedge clk);
      if (mif.imem_req) nreq++;
    end
    chk("to_req_cycles", nreq, 8);
    repeat (3) @(negedge clk);
    chk("to_fault", fault, 1'b1);
    chk("to_imem_req", mif.imem_req, 1'b0);
    chk("to_dmem_req", mif.dmem_req, 1'b0);
    chk("to_retire", retire, 1'b0);
    chk("to_pc", pc_address, 32'd0);

    @(negedge clk);
    #2;
    rst = 1'b0;
    imem_en = 1'b1;
    imem[0] = 32'h00002083;
    push(0, 32'd0, 32'd0, 0, 8, 1, 0, 32'd0, 32'd0);
    #5;
    rst = 1'b1;
    for (int i = 0; i < 40 && !fault; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("dto_fault", fault, 1'b1);
    chk("dto_dmem_req", mif.dmem_req, 1'b0);
    chk("dto_pc", pc_address, 32'd0);
    chk("dto_x1", reg1_output, 32'd72);
    sb.delete();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multi_cycle_core.md
MULTI_CYCLE_CORE -- requirements
Module: multi_cycle_core

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 16, max wait cycles for a memory ack (0 disables the timeout).
REQ-003 clk  input  1  single clock, all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  instruction fetch request, held until imem_ack.
REQ-006 imem_addr  output  32  fetch address, equals pc_address.
REQ-007 imem_ack  input  1  fetch complete; imem_rdata valid in the same cycle.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 dmem_req  output  1  data access request, held until dmem_ack.
REQ-010 dmem_we  output  1  1 = store, 0 = load; valid while dmem_req is high.
REQ-011 dmem_addr  output  32  word-aligned data address.
REQ-012 dmem_wdata  output  32  store data (rs2).
REQ-013 dmem_ack  input  1  access complete; dmem_rdata valid in the same cycle for loads.
REQ-014 dmem_rdata  input  32  load data.
REQ-015 pc_address  output  32  current PC register.
REQ-016 alu_output  output  32  latched ALU result register.
REQ-017 reg1_output  output  32  architectural register x1.
REQ-018 retire  output  1  one-cycle pulse in the WB cycle of each completed instruction.
REQ-019 fault  output  1  sticky fault flag.

Function
REQ-020 The core SHALL execute RV32I integer, LUI, AUIPC, JAL, JALR, branch, LW and SW instructions using the team decoder, alu, branch and regfile units, with a multi-cycle FSM: FETCH(0), DECODE(1), EXECUTE(2), MEM(3), WB(4), FAULT(7).
REQ-021 FETCH: imem_req=1 and imem_addr=PC; on imem_ack, latch imem_rdata into the IR and move to DECODE.
REQ-022 DECODE: latch rs1/rs2 regfile data into operand registers; move to EXECUTE.
REQ-023 EXECUTE: latch the ALU result into alu_output and evaluate the branch condition; LW/SW go to MEM, all other instructions go to WB.
REQ-024 MEM: dmem_req=1, dmem_addr=alu_output, dmem_we=1 for SW; on dmem_ack, latch dmem_rdata for LW and move to WB.
REQ-025 WB: write rd only for instructions that have a destination, with x0 never written. Write data is PC+4 for JAL/JALR, the latched load data for LW, and alu_output otherwise.
REQ-026 WB also updates the PC to alu_output for a jump or a taken branch, else to PC+4 (modulo 2^32). It then pulses retire and moves to FETCH.
REQ-027 Registers are written only in WB. The PC changes only in WB or on reset.
REQ-028 Latency with zero-wait memory (ack in the request cycle): 4 cycles for non-memory instructions, 5 cycles for LW/SW. Each wait cycle adds one cycle.
REQ-029 The address, dmem_we and dmem_wdata SHALL stay stable while a request is high. An ack arriving while no request is pending SHALL be ignored.
REQ-030 A wait counter SHALL clear on entry to FETCH/MEM and count each request cycle without ack. If TIMEOUT≠0 and the count reaches TIMEOUT, the core SHALL enter FAULT.
REQ-031 The following SHALL enter FAULT from EXECUTE with no MEM access and no register write:
  - an LW/SW whose address[1:0]≠0;
  - a load/store opcode whose funct3≠010;
  - an unrecognised opcode.
REQ-032 FAULT: fault=1, both request outputs low, retire low, PC frozen. FAULT is left only by reset.
REQ-033 An ack arriving in the same cycle that the timeout is reached SHALL take priority: the access completes and no fault is raised.

Reset
REQ-034 While rst=0, asynchronously force:
  - state=FETCH, PC=RESET_PC;
  - IR, operand registers, alu_output, load-data register and wait counter = 0;
  - fault=0, retire=0, imem_req=0, dmem_req=0, dmem_we=0.
REQ-035 Reset asserted mid-access SHALL abandon the access immediately. The first edge after release SHALL present imem_req=1 with imem_addr=RESET_PC.
REQ-036 The regfile contents are not reset.

Verification
REQ-037 Reset while acks toggle -> pc_address=RESET_PC, imem_req=0, fault=0. Release -> imem_req=1 and imem_addr=RESET_PC in the next cycle.
REQ-038 Zero-wait ADDI x1,x0,5 (0x00500093) at PC 0 -> retire pulses in cycle 4, reg1_output=5, pc_address=4.
REQ-039 LW x1,0(x2) with x2=0x10 and dmem_ack 3 cycles late -> dmem_req held with dmem_addr=0x10 stable. The instruction then completes with reg1_output=0xDEADBEEF and retire in cycle 8.
REQ-040 SW x1,4(x0) with x1=5 -> dmem_we=1, dmem_addr=4, dmem_wdata=5, no register change. BEQ x0,x0,+8 at PC 4 -> PC=12. JAL x1,+16 at PC 12 -> x1=16, PC=28.
REQ-041 With TIMEOUT=8 and imem_ack never asserted -> fault=1 after 8 request cycles, with requests low and the PC frozen.
REQ-042 A misaligned LW (address 0x11) -> fault=1 with no dmem_req. A separate case with ack and timeout in the same cycle -> no fault.
